// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: parameter legality checks for the read-side
// stream adapter and the beat counter width derivation.
package fifo_pkg;

    function automatic bit is_pow2(input int value);
        return (value > 32'sd0) && ((value & (value - 32'sd1)) == 32'sd0);
    endfunction

    function automatic bit buf_depth_ok(input int depth);
        return is_pow2(depth) && (depth >= 32'sd2);
    endfunction

    function automatic bit burst_len_ok(input int burst_len);
        return burst_len >= 32'sd1;
    endfunction

    // A single-beat burst still needs a one-bit counter port.
    function automatic int beat_width(input int burst_len);
        return (burst_len > 32'sd1) ? $clog2(burst_len) : 32'sd1;
    endfunction

endpackage

// File: rtl/stream_buf.sv
// Register-array circular buffer with push/pop/flush and an occupancy count.
// Storage is cleared only by reset; flush just rewinds pointers and count.
module stream_buf #(
    parameter int  DATA_WIDTH = 4,
    parameter int  DEPTH      = 4,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic [CNT_W-1:0]      o_count
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  w_push;
    logic                  w_pop;

    assign w_push = i_push && !i_flush;
    assign w_pop  = i_pop && !i_flush && (r_count != {CNT_W{1'b0}});

    // Storage array: zeroed on reset, written at the write pointer on push.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain adapter: credit-limited FIFO reads feeding a small buffer,
// presented as a valid/ready stream with m_last framing every BURST_LEN beats.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int BUF_DEPTH  = 4,
    parameter int BURST_LEN  = 8
) (
    input  logic                             rd_clk,
    input  logic                             rd_rst,
    input  logic                             flush,
    input  logic                             fifo_empty,
    output logic                             fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]            fifo_rd_data,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [DATA_WIDTH-1:0]            m_data,
    output logic                             m_last,
    output logic [beat_width(BURST_LEN)-1:0] beat_cnt
);

    localparam int                CNT_W     = $clog2(BUF_DEPTH) + 1;
    localparam int                BEAT_W    = beat_width(BURST_LEN);
    localparam logic [CNT_W:0]    DEPTH_C   = (CNT_W + 1)'(BUF_DEPTH);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    if (!buf_depth_ok(BUF_DEPTH) || !burst_len_ok(BURST_LEN)) begin : g_param_check
        $fatal(1, "fifo_rd_stream: illegal BUF_DEPTH or BURST_LEN");
    end

    logic [CNT_W-1:0]  w_count;
    logic [CNT_W:0]    w_credit_used;
    logic              w_credit_ok;
    logic              w_push;
    logic              w_pop;
    logic              r_inflight;
    logic [BEAT_W-1:0] r_beat;

    // A word already requested occupies a credit until it lands in the buffer.
    assign w_credit_used = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_credit_ok   = (w_credit_used < DEPTH_C);
    assign fifo_rd_en    = !rd_rst && !flush && !fifo_empty && w_credit_ok;

    assign w_push  = r_inflight && !flush;
    assign m_valid = (w_count != {CNT_W{1'b0}});
    assign w_pop   = m_valid && m_ready;

    stream_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_buf (
        .i_clk       (rd_clk),
        .i_rst       (rd_rst),
        .i_flush     (flush),
        .i_push      (w_push),
        .i_push_data (fifo_rd_data),
        .i_pop       (w_pop),
        .o_rd_data   (m_data),
        .o_count     (w_count)
    );

    // In-flight tracking and beat position within the current burst.
    always_ff @(posedge rd_clk) begin
        if (rd_rst || flush) begin
            r_inflight <= 1'b0;
            r_beat     <= {BEAT_W{1'b0}};
        end else begin
            r_inflight <= fifo_rd_en;
            if (w_pop) begin
                r_beat <= (r_beat == LAST_BEAT) ? {BEAT_W{1'b0}} : r_beat + 1'b1;
            end
        end
    end

    assign m_last   = m_valid && (r_beat == LAST_BEAT);
    assign beat_cnt = r_beat;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO model on the read side, scoreboard
// of expected stream words, table-driven bursts plus stall/flush/reset sequences.
`timescale 1ns/1ps
module tb_fifo_rd_stream;

    localparam int DW = 4;
    localparam int BD = 4;
    localparam int BL = 8;

    typedef struct {
        int          n_words;
        int          ready_pct;
        logic [DW-1:0] base;
        int          exp_beats;
        int          exp_lasts;
    } vec_t;

    logic          rd_clk = 1'b0;
    logic          rd_rst;
    logic          flush;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [2:0]    beat_cnt;

    int n_chk    = 0;
    int n_fail   = 0;
    int xfer_cnt = 0;
    int last_cnt = 0;
    int rd_cnt   = 0;
    int exp_beat = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic          rd_en_s;

    always #5 rd_clk = ~rd_clk;

    fifo_rd_stream #(.DATA_WIDTH(DW), .BUF_DEPTH(BD), .BURST_LEN(BL)) dut (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .flush        (flush),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .beat_cnt     (beat_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural FIFO: data appears one cycle after the read strobe.
    initial begin
        fifo_empty   = 1'b1;
        fifo_rd_data = '0;
        forever begin
            @(negedge rd_clk);
            rd_en_s = fifo_rd_en;
            @(posedge rd_clk);
            #1;
            if (rd_en_s) begin
                rd_cnt++;
                chk("rd_not_empty", 32'(fifo_q.size() > 0), 32'd1);
                if (fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
            end
            fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Stream monitor / scoreboard.
    initial begin
        logic [DW-1:0] exp_w;
        forever begin
            @(negedge rd_clk);
            chk("count_bound", 32'(dut.w_count <= 3'd4), 32'd1);
            if (rd_rst || flush) begin
                exp_beat = 0;
            end else if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got data %0h, expected no beat", m_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("m_data", 32'(m_data), 32'(exp_w));
                end
                chk("beat_cnt", 32'(beat_cnt), 32'(exp_beat));
                chk("m_last", 32'(m_last), 32'(exp_beat == BL - 1));
                if (m_last) last_cnt++;
                exp_beat = (exp_beat == BL - 1) ? 0 : exp_beat + 1;
                xfer_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic load(input int n, input logic [DW-1:0] base);
        logic [DW-1:0] w;
        w = base;
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(w);
            exp_q.push_back(w);
            w = w + 4'd1;
        end
    endtask

    task automatic do_flush();
        @(posedge rd_clk); #1; flush = 1'b1;
        @(posedge rd_clk); #1; flush = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 3000; i++) begin
            @(posedge rd_clk); #1;
            if (exp_q.size() == 0 && fifo_q.size() == 0) break;
        end
        repeat (4) @(posedge rd_clk);
        chk({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        vec_t          vecs[4];
        logic [5:1]    exp_v;
        logic          found;
        int            x0, l0, r0;

        vecs[0] = '{16,  100, 4'h0, 16,  2};
        vecs[1] = '{100, 50,  4'h0, 100, 12};
        vecs[2] = '{5,   30,  4'h7, 5,   0};
        vecs[3] = '{9,   75,  4'hC, 9,   1};

        rd_rst = 1'b1; flush = 1'b0; m_ready = 1'b0;
        repeat (3) @(posedge rd_clk);
        @(negedge rd_clk);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        @(posedge rd_clk); #1; rd_rst = 1'b0;

        // First-word latency and single-beat throughput.
        m_ready = 1'b1;
        load(3, 4'h1);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge rd_clk);
            if (fifo_rd_en) begin found = 1'b1; break; end
        end
        chk("first_rd_en", 32'(found), 32'd1);
        exp_v = 5'b01110;
        for (int k = 1; k <= 5; k++) begin
            @(negedge rd_clk);
            chk($sformatf("latency_v%0d", k), 32'(m_valid), 32'(exp_v[k]));
        end
        wait_drain("three_words");

        // Table of bursts with varying back-pressure.
        foreach (vecs[v]) begin
            do_flush();
            x0 = xfer_cnt; l0 = last_cnt;
            load(vecs[v].n_words, vecs[v].base);
            for (int c = 0; c < 3000; c++) begin
                @(posedge rd_clk); #1;
                m_ready = ($urandom_range(0, 99) < vecs[v].ready_pct);
                if ((xfer_cnt - x0) >= vecs[v].exp_beats && exp_q.size() == 0) break;
            end
            m_ready = 1'b0;
            chk($sformatf("vec%0d_beats", v), 32'(xfer_cnt - x0), 32'(vecs[v].exp_beats));
            chk($sformatf("vec%0d_lasts", v), 32'(last_cnt - l0), 32'(vecs[v].exp_lasts));
            chk($sformatf("vec%0d_left", v), 32'(exp_q.size()), 32'd0);
        end

        // Stall: credits stop reads at BUF_DEPTH, head word holds.
        do_flush();
        m_ready = 1'b0;
        r0 = rd_cnt;
        load(10, 4'h3);
        repeat (20) @(posedge rd_clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge rd_clk);
            chk("stall_valid", 32'(m_valid), 32'd1);
            chk("stall_data", 32'(m_data), 32'h3);
            chk("stall_beat", 32'(beat_cnt), 32'd0);
        end
        chk("stall_reads", 32'(rd_cnt - r0), 32'd4);
        chk("stall_count", 32'(dut.w_count), 32'd4);
        @(posedge rd_clk); #1; m_ready = 1'b1;
        wait_drain("stall");
        m_ready = 1'b0;

        // Flush with two buffered words and one in flight.
        do_flush();
        load(8, 4'h9);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge rd_clk); #1;
            if (dut.w_count == 3'd2 && dut.r_inflight) begin found = 1'b1; break; end
        end
        chk("flush_setup", 32'(found), 32'd1);
        flush = 1'b1;
        @(negedge rd_clk);
        exp_q = fifo_q;
        chk("flush_lost", 32'(exp_q.size()), 32'd5);
        @(posedge rd_clk); #1; flush = 1'b0;
        @(negedge rd_clk);
        chk("flush_m_valid", 32'(m_valid), 32'd0);
        chk("flush_beat", 32'(beat_cnt), 32'd0);
        chk("flush_next_word", 32'(exp_q[0]), 32'hC);
        @(posedge rd_clk); #1; m_ready = 1'b1;
        wait_drain("flush");

        // Reset mid-burst at beat 3.
        do_flush();
        load(16, 4'h0);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge rd_clk);
            if (m_valid && beat_cnt == 3'd3) begin found = 1'b1; break; end
        end
        chk("rst_beat3_seen", 32'(found), 32'd1);
        @(posedge rd_clk); #1; rd_rst = 1'b1;
        @(negedge rd_clk);
        chk("rst_rd_en_comb", 32'(fifo_rd_en), 32'd0);
        exp_q = fifo_q;
        @(posedge rd_clk); #1;
        @(negedge rd_clk);
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        chk("midrst_m_data", 32'(m_data), 32'd0);
        chk("midrst_m_last", 32'(m_last), 32'd0);
        chk("midrst_beat", 32'(beat_cnt), 32'd0);
        @(posedge rd_clk); #1; rd_rst = 1'b0;
        @(negedge rd_clk);
        chk("post_rst_rd_en", 32'(fifo_rd_en), 32'd1);
        wait_drain("reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
